// File: rtl/usr_shift_sequencer.sv
// Command-driven controller for an N-bit universal shift register: accepts one
// load/shift/rotate command at a time and steps the register through it.
module usr_shift_sequencer #(
   parameter int N     = 4,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic [N-1:0]     cmd_data,
   input  logic             fill_bit,
   input  logic [N-1:0]     q,
   output logic [1:0]       s,
   output logic             msb_in,
   output logic             lsb_in,
   output logic [N-1:0]     par_out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SHR  = 3'b010;
   localparam logic [2:0] OP_SHL  = 3'b011;
   localparam logic [2:0] OP_ROR  = 3'b100;
   localparam logic [2:0] OP_ROL  = 3'b101;

   localparam logic [1:0] S_HOLD = 2'b00;
   localparam logic [1:0] S_SHR  = 2'b01;
   localparam logic [1:0] S_SHL  = 2'b10;
   localparam logic [1:0] S_LOAD = 2'b11;

   state_t           state, state_n;
   logic [2:0]       op_r;
   logic [AMT_W-1:0] cnt;
   logic             fill_r;
   logic [AMT_W-1:0] k;
   logic             accept;
   logic             q_unused;

   // Only the end bits of q feed the rotates; the rest is deliberately ignored.
   assign q_unused = ^q;

   assign accept = cmd_valid && (state == IDLE);

   // Number of USR steps the incoming command needs; zero skips EXEC entirely.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      k = '0;
      case (cmd_op)
         OP_LOAD:                        k = AMT_W'(1);
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: k = cmd_amt;
         default:                        k = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
      if (!reset_n) begin
         state   <= IDLE;
         op_r    <= OP_NOP;
         cnt     <= '0;
         fill_r  <= 1'b0;
         par_out <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            op_r    <= cmd_op;
            cnt     <= k;
            fill_r  <= fill_bit;
            par_out <= cmd_data;
         end else if (state == EXEC) begin
            cnt <= cnt - AMT_W'(1);
         end
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = (k != '0) ? EXEC : DONE;
         EXEC:    if (cnt == AMT_W'(1)) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // USR controls are live only in EXEC; rotates read q as presented each cycle.
   always_comb begin
      s      = S_HOLD;
      msb_in = 1'b0;
      lsb_in = 1'b0;
      if (state == EXEC) begin
         case (op_r)
            OP_LOAD: s = S_LOAD;
            OP_SHR:  begin s = S_SHR; msb_in = fill_r; end
            OP_SHL:  begin s = S_SHL; lsb_in = fill_r; end
            OP_ROR:  begin s = S_SHR; msb_in = q[0];   end
            OP_ROL:  begin s = S_SHL; lsb_in = q[N-1]; end
            default: s = S_HOLD;
         endcase
      end
   end

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == EXEC) || (state == DONE);
   assign done      = (state == DONE);
   assign err       = (state == DONE) && (op_r[2:1] == 2'b11);

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench for usr_shift_sequencer driving a behavioural 4-bit USR.
module tb_usr_shift_sequencer;

   localparam int N     = 4;
   localparam int AMT_W = 3;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SHR  = 3'b010;
   localparam logic [2:0] OP_SHL  = 3'b011;
   localparam logic [2:0] OP_ROR  = 3'b100;
   localparam logic [2:0] OP_ROL  = 3'b101;

   typedef struct {
      logic [2:0]       op;
      logic [AMT_W-1:0] amt;
      logic [N-1:0]     data;
      logic             fill;
      logic [N-1:0]     exp_q;
      int               exp_k;
      logic [1:0]       exp_s;
      logic             exp_err;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [AMT_W-1:0] cmd_amt;
   logic [N-1:0]     cmd_data;
   logic             fill_bit;
   logic [N-1:0]     q = '0;
   logic [1:0]       s;
   logic             msb_in;
   logic             lsb_in;
   logic [N-1:0]     par_out;
   logic             busy;
   logic             done;
   logic             err;

   int checks   = 0;
   int failures = 0;

   vec_t vecs [17];

   usr_shift_sequencer #(.N(N), .AMT_W(AMT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_amt   (cmd_amt),
      .cmd_data  (cmd_data),
      .fill_bit  (fill_bit),
      .q         (q),
      .s         (s),
      .msb_in    (msb_in),
      .lsb_in    (lsb_in),
      .par_out   (par_out),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Behavioural universal shift register (not reset, so it keeps its value across reset_n).
   always @(posedge clk) begin
      case (s)
         2'b01:   q <= {msb_in, q[N-1:1]};
         2'b10:   q <= {q[N-2:0], lsb_in};
         2'b11:   q <= par_out;
         default: q <= q;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_cmd(input vec_t v, input string tag);
      int  steps;
      int  cyc;
      bit  got_done;
      logic exp_bit;
      @(negedge clk);
      check({tag, "_ready_before"}, cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_amt   = v.amt;
      cmd_data  = v.data;
      fill_bit  = v.fill;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 3'b110;
      cmd_data  = ~v.data;
      fill_bit  = ~v.fill;
      steps     = 0;
      cyc       = 0;
      got_done  = 1'b0;
      while (!got_done && cyc < 40) begin
         if (done) begin
            got_done = 1'b1;
         end else begin
            if (s != 2'b00) begin
               steps++;
               check({tag, "_s"}, s, v.exp_s);
               if (s == 2'b01) begin
                  exp_bit = (v.op == OP_ROR) ? q[0] : v.fill;
                  check({tag, "_msb_in"}, msb_in, exp_bit);
               end else if (s == 2'b10) begin
                  exp_bit = (v.op == OP_ROL) ? q[N-1] : v.fill;
                  check({tag, "_lsb_in"}, lsb_in, exp_bit);
               end
            end
            cyc++;
            @(negedge clk);
         end
      end
      check({tag, "_done_seen"}, got_done, 1);
      check({tag, "_cycles"}, cyc, v.exp_k);
      check({tag, "_steps"}, steps, v.exp_k);
      check({tag, "_q"}, q, v.exp_q);
      check({tag, "_err"}, err, v.exp_err);
      check({tag, "_par_out"}, par_out, v.data);
      check({tag, "_busy_done"}, busy, 1);
      @(negedge clk);
      check({tag, "_done_clear"}, {done, err}, 2'b00);
      check({tag, "_ready_after"}, {cmd_ready, busy}, 2'b10);
   endtask

   initial begin
      int  cyc;
      bit  saw_done;
      bit  got_done;

      vecs[0]  = '{OP_LOAD, 3'd5, 4'b1011, 1'b0, 4'b1011, 1, 2'b11, 1'b0};
      vecs[1]  = '{OP_SHR,  3'd2, 4'b0100, 1'b1, 4'b1110, 2, 2'b01, 1'b0};
      vecs[2]  = '{OP_LOAD, 3'd0, 4'b1011, 1'b1, 4'b1011, 1, 2'b11, 1'b0};
      vecs[3]  = '{OP_ROL,  3'd1, 4'b0001, 1'b0, 4'b0111, 1, 2'b10, 1'b0};
      vecs[4]  = '{OP_LOAD, 3'd7, 4'b1011, 1'b0, 4'b1011, 1, 2'b11, 1'b0};
      vecs[5]  = '{OP_ROR,  3'd4, 4'b1100, 1'b0, 4'b1011, 4, 2'b01, 1'b0};
      vecs[6]  = '{OP_SHL,  3'd0, 4'b0011, 1'b1, 4'b1011, 0, 2'b00, 1'b0};
      vecs[7]  = '{OP_NOP,  3'd3, 4'b1111, 1'b1, 4'b1011, 0, 2'b00, 1'b0};
      vecs[8]  = '{3'b111,  3'd3, 4'b0101, 1'b1, 4'b1011, 0, 2'b00, 1'b1};
      vecs[9]  = '{3'b110,  3'd0, 4'b1010, 1'b0, 4'b1011, 0, 2'b00, 1'b1};
      vecs[10] = '{OP_SHL,  3'd7, 4'b1001, 1'b0, 4'b0000, 7, 2'b10, 1'b0};
      vecs[11] = '{OP_LOAD, 3'd1, 4'b0110, 1'b0, 4'b0110, 1, 2'b11, 1'b0};
      vecs[12] = '{OP_SHR,  3'd5, 4'b0010, 1'b1, 4'b1111, 5, 2'b01, 1'b0};
      vecs[13] = '{OP_LOAD, 3'd2, 4'b1000, 1'b1, 4'b1000, 1, 2'b11, 1'b0};
      vecs[14] = '{OP_ROL,  3'd5, 4'b0111, 1'b1, 4'b0001, 5, 2'b10, 1'b0};
      vecs[15] = '{OP_ROR,  3'd1, 4'b1110, 1'b0, 4'b1000, 1, 2'b01, 1'b0};
      vecs[16] = '{OP_SHL,  3'd2, 4'b0000, 1'b1, 4'b0011, 2, 2'b10, 1'b0};

      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_amt   = '0;
      cmd_data  = '0;
      fill_bit  = 1'b0;

      #3;
      check("reset_ready", cmd_ready, 1);
      check("reset_s", s, 2'b00);
      check("reset_flags", {busy, done, err, msb_in, lsb_in}, 5'b00000);
      check("reset_par_out", par_out, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         run_cmd(vecs[i], $sformatf("vec%0d", i));
      end

      // cmd_valid held high with a second command while SHR amt=3 runs.
      run_cmd('{OP_LOAD, 3'd0, 4'b1011, 1'b0, 4'b1011, 1, 2'b11, 1'b0}, "hold_load");
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = OP_SHR;
      cmd_amt   = 3'd3;
      cmd_data  = 4'b0000;
      fill_bit  = 1'b0;
      @(negedge clk);
      cmd_op    = OP_SHL;
      cmd_amt   = 3'd1;
      cmd_data  = 4'b0101;
      fill_bit  = 1'b1;
      cyc       = 0;
      got_done  = 1'b0;
      while (!got_done && cyc < 40) begin
         if (done) got_done = 1'b1;
         else begin
            cyc++;
            @(negedge clk);
         end
      end
      check("hold_done_seen", got_done, 1);
      check("hold_first_cycles", cyc, 3);
      check("hold_first_q", q, 4'b0001);
      check("hold_first_par_out", par_out, 4'b0000);
      check("hold_ready_in_done", cmd_ready, 0);
      @(negedge clk);
      check("hold_idle", {cmd_ready, s}, 3'b100);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("hold_second_s", {s, lsb_in, busy}, 4'b1011);
      @(negedge clk);
      check("hold_second_done", done, 1);
      check("hold_second_q", q, 4'b0011);
      check("hold_second_par_out", par_out, 4'b0101);
      @(negedge clk);
      check("hold_end", {done, cmd_ready, s}, 4'b0100);

      // Reset during the second step of SHL amt=3.
      run_cmd('{OP_LOAD, 3'd0, 4'b1011, 1'b0, 4'b1011, 1, 2'b11, 1'b0}, "rst_load");
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = OP_SHL;
      cmd_amt   = 3'd3;
      cmd_data  = 4'b1001;
      fill_bit  = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("rst_step1_s", s, 2'b10);
      @(negedge clk);
      check("rst_step2_s", s, 2'b10);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async_s", s, 2'b00);
      check("rst_async_state", {cmd_ready, busy, done}, 3'b100);
      check("rst_async_par_out", par_out, 4'b0000);
      @(negedge clk);
      reset_n  = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done || !cmd_ready || s != 2'b00) saw_done = 1'b1;
      end
      check("rst_no_done", saw_done, 0);
      check("rst_q_kept", q, 4'b0110);
      run_cmd('{OP_ROR, 3'd2, 4'b0011, 1'b0, 4'b1001, 2, 2'b01, 1'b0}, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/usr_shift_sequencer.md
Name: usr_shift_sequencer

Overview:
Command-driven controller that sequences an n-bit universal shift register (USR) instance.
- Accepts one command at a time over a valid/ready handshake.
- Drives the USR mode select, serial inputs and parallel-load word to perform a load, a multi-bit shift or a multi-bit rotate.
- Signals completion with a one-cycle done pulse, at which point the register already holds the result.
- Sits between a host/datapath FSM and the USR; reads the USR Q output back for rotate feedback.

Parameters:
- N, 4, width of the sequenced shift register; must be >= 2.
- AMT_W, 3, width of the shift-amount field; 2^AMT_W-1 >= N.

Ports:
- clk  input  1  rising-edge clock shared with the USR.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  high when the sequencer can accept a command; equals (state==IDLE).
- cmd_op  input  3  operation code (see Behaviour).
- cmd_amt  input  AMT_W  number of shift/rotate steps.
- cmd_data  input  N  parallel word for LOAD.
- fill_bit  input  1  serial fill value for SHR/SHL.
- q  input  N  USR Q feedback.
- s  output  2  USR mode select: 00 hold, 01 shift right (msb_in enters MSB), 10 shift left (lsb_in enters LSB), 11 parallel load.
- msb_in  output  1  USR Msb_in.
- lsb_in  output  1  USR Lsb_in.
- par_out  output  N  USR parallel input I.
- busy  output  1  high in EXEC or DONE.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse coincident with done for an illegal opcode.

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE, so cmd_ready=1.
  - s=00, msb_in=0, lsb_in=0, par_out=0, busy=0, done=0, err=0.
  - Internal count, op and fill registers are cleared.
- Opcodes:
  - 000 NOP.
  - 001 LOAD: one step, s=11, par_out=captured cmd_data; cmd_amt is ignored.
  - 010 SHR: s=01, msb_in=captured fill_bit.
  - 011 SHL: s=10, lsb_in=captured fill_bit.
  - 100 ROR: s=01, msb_in=q[0].
  - 101 ROL: s=10, lsb_in=q[N-1].
  - 110/111 illegal: behave as NOP and pulse err with done.
- Acceptance:
  - A command is accepted on a rising edge where cmd_valid && cmd_ready (edge E0).
  - On E0, op, amt, data and fill are captured into registers.
  - cmd_* inputs are don't-care at all other times.
- States:
  - IDLE: s=00. On accept, go to EXEC if the step count k>0; otherwise go to DONE. k=1 for LOAD, k=cmd_amt for shift/rotate, k=0 for NOP, illegal ops or amt=0.
  - EXEC: s, msb_in and lsb_in are driven combinationally from the captured op, and from q for rotates. Each edge in EXEC commits one USR step and decrements the count. When count==1 on an edge, go to DONE. Exactly k steps occur, on edges E1..Ek.
  - DONE: s=00, done=1 for one cycle, err=1 if the opcode was illegal; then go to IDLE.
- Latency and throughput:
  - done is high during the cycle after edge Ek; q equals the final result in that cycle.
  - A command occupies k+2 cycles from acceptance edge to the next possible acceptance (k=0 gives 2 cycles).
- Outputs:
  - s, msb_in and lsb_in are combinational from registered state and q; there is no combinational path from cmd_* to any output.
  - par_out is registered: held from E0 until the next accept, and 0 after reset.
- Shift amount:
  - amt > N is executed literally (SHR/SHL saturate to all-fill; rotates wrap modulo N naturally).
  - amt == N rotate returns the original value.
- Boundary conditions:
  - cmd_valid while busy: ignored, not queued, no side effects.
  - reset_n low mid-EXEC: s forced to 00 immediately; no done pulse; the command is lost.
  - q changes externally during EXEC: rotate feedback uses q as currently presented each cycle.

Test Plan:
- Reset → cmd_ready=1, s=00, busy=0, done=0. LOAD cmd_data=4'b1011 → s=11 for exactly one cycle; done pulses the next cycle with q=1011.
- q=1011, SHR amt=2 fill=1 → s=01 for 2 cycles, msb_in=1; q=1101 then 1110; done with q=1110, total 4 cycles accept-to-ready.
- q=1011, ROL amt=1 → lsb_in=1, q=0111, done. ROR amt=4 from 1011 → q=1011 at done.
- SHL amt=0, and separately op=000 → no s≠00 cycle; done one cycle after accept with err=0. op=111 → done and err pulse together, q unchanged.
- Hold cmd_valid high with a second command during an SHR amt=3 → second command accepted only on the first edge after DONE (cmd_ready=1); no extra shifts.
- Assert reset_n low during the 2nd step of SHL amt=3 → s=00 asynchronously, no done, cmd_ready=1 after release.
